// File: rtl/des_key_schedule_pkg.sv
// DES key schedule constants: PC-1/PC-2 selection tables, shift table,
// widths and the small rotate/permute helpers shared by the schedule RTL.
package des_key_schedule_pkg;

    localparam int KEY_W  = 64;
    localparam int HALF_W = 28;
    localparam int RK_W   = 48;
    localparam int ROUNDS = 16;

    // Tables use DES bit numbering: entry value 1 is the MSB of the source.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount for round r is SHIFT_TBL[r-1]; the entries sum to 28.
    localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [2*HALF_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [2*HALF_W-1:0] r;
        r = '0;
        for (int i = 0; i < 2*HALF_W; i++)
            r[2*HALF_W-1-i] = k[KEY_W-PC1_TBL[i]];
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int n);
        return (x >> n) | (x << (HALF_W - n));
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load and round-key handshake bundle between key source, schedule and
// the round engine. slave = schedule side, master = key source / consumer.
interface des_key_schedule_if;
    import des_key_schedule_pkg::*;

    logic [KEY_W-1:0] key_i;
    logic             decrypt_i;
    logic             key_valid_i;
    logic             key_ready_o;
    logic [RK_W-1:0]  round_key_o;
    logic [3:0]       round_idx_o;
    logic             round_key_valid_o;
    logic             round_key_ready_i;
    logic             last_o;

    modport slave (
        input  key_i, decrypt_i, key_valid_i, round_key_ready_i,
        output key_ready_o, round_key_o, round_idx_o, round_key_valid_o, last_o
    );

    modport master (
        output key_i, decrypt_i, key_valid_i, round_key_ready_i,
        input  key_ready_o, round_key_o, round_idx_o, round_key_valid_o, last_o
    );
endinterface

// File: rtl/des_key_schedule_pc2.sv
// PC-2 compression: pure 56->48 bit selection from the registered C||D.
module des_key_schedule_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [2*HALF_W-1:0] cd,
    output logic [RK_W-1:0]     rk
);

    // Straight wiring; no gates sit between the C/D flops and the round key.
    always_comb begin
        rk = '0;
        for (int i = 0; i < RK_W; i++)
            rk[RK_W-1-i] = cd[2*HALF_W-PC2_TBL[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads a key once, then streams K1..K16
// (encrypt) or K16..K1 (decrypt) one round key per consumer handshake.
module des_key_schedule
    import des_key_schedule_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_schedule_if.slave    bus
);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        idx_q, idx_d;
    logic              dec_q, dec_d;
    logic [2*HALF_W-1:0] cd0;
    logic              adv;

    assign cd0 = pc1(bus.key_i);
    assign adv = (state_q == RUN) && bus.round_key_ready_i;

    // State and C/D registers; reset puts the schedule back to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state: load (C1,D1) or (C16,D16) on key accept, then rotate per handshake.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid_i) begin
                    // Decrypt starts at C16/D16, which equals C0/D0 since shifts total 28.
                    if (bus.decrypt_i) begin
                        c_d = cd0[2*HALF_W-1:HALF_W];
                        d_d = cd0[HALF_W-1:0];
                    end else begin
                        c_d = rotl(cd0[2*HALF_W-1:HALF_W], 1);
                        d_d = rotl(cd0[HALF_W-1:0], 1);
                    end
                    idx_d   = '0;
                    dec_d   = bus.decrypt_i;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (adv) begin
                    if (dec_q) begin
                        // Undo the shift of the key just emitted; on the last one
                        // this lands back on C0/D0.
                        c_d = rotr(c_q, SHIFT_TBL[15-int'(idx_q)]);
                        d_d = rotr(d_q, SHIFT_TBL[15-int'(idx_q)]);
                    end else if (idx_q != 4'd15) begin
                        c_d = rotl(c_q, SHIFT_TBL[int'(idx_q)+1]);
                        d_d = rotl(d_q, SHIFT_TBL[int'(idx_q)+1]);
                    end
                    if (idx_q == 4'd15) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    des_key_schedule_pc2 u_pc2 (
        .cd (({c_q, d_q})),
        .rk (bus.round_key_o)
    );

    assign bus.key_ready_o       = (state_q == IDLE);
    assign bus.round_key_valid_o = (state_q == RUN);
    assign bus.round_idx_o       = idx_q;
    assign bus.last_o            = (state_q == RUN) && (idx_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for the DES key schedule using the classic 0x133457799BBCDFF1 vector.
module tb_des_key_schedule;
    import des_key_schedule_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR_MSK = 64'h0101010101010101;

    // K1..K16 for KEY_A, worked out by hand from PC-1/shift/PC-2.
    localparam logic [47:0] ENC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_key(input logic [63:0] k, input bit dec);
        int b;
        b = 0;
        @(negedge clk);
        bus.key_i = k;
        bus.decrypt_i = dec;
        bus.key_valid_i = 1'b1;
        bus.round_key_ready_i = 1'b1;
        while (!bus.key_ready_o && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!bus.key_ready_o) chk("key_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.decrypt_i = ~dec;
    endtask

    task automatic collect(input string pfx, input bit dec, input bit bp, input bit inject);
        bit          stall;
        logic [47:0] pk;
        logic [3:0]  pi;
        int          i;
        int          budget;
        stall = 1'b0; pk = '0; pi = '0; i = 0; budget = 0;
        while (i < 16 && budget < 400) begin
            @(negedge clk);
            budget++;
            bus.key_valid_i = inject;
            if (inject) bus.key_i = '1;
            if (stall) begin
                chk({pfx, "_hold_key"}, 64'(bus.round_key_o), 64'(pk));
                chk({pfx, "_hold_idx"}, 64'(bus.round_idx_o), 64'(pi));
            end
            if (budget == 1) chk({pfx, "_first_valid"}, 64'(bus.round_key_valid_o), 64'd1);
            bus.round_key_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = bus.round_key_valid_o && !bus.round_key_ready_i;
            pk = bus.round_key_o;
            pi = bus.round_idx_o;
            if (bus.round_key_valid_o && bus.round_key_ready_i) begin
                chk($sformatf("%s_k%0d", pfx, i), 64'(bus.round_key_o),
                    64'(dec ? ENC[15-i] : ENC[i]));
                chk($sformatf("%s_idx%0d", pfx, i), 64'(bus.round_idx_o), 64'(i));
                chk($sformatf("%s_last%0d", pfx, i), 64'(bus.last_o), 64'(i == 15));
                if (i == 3) chk({pfx, "_busy_ready"}, 64'(bus.key_ready_o), 64'd0);
                i++;
            end
        end
        if (i < 16) chk({pfx, "_timeout"}, 64'(i), 64'd16);
        @(negedge clk);
        bus.key_valid_i = 1'b0;
        chk({pfx, "_done_ready"}, 64'(bus.key_ready_o), 64'd1);
        chk({pfx, "_done_valid"}, 64'(bus.round_key_valid_o), 64'd0);
        chk({pfx, "_done_last"}, 64'(bus.last_o), 64'd0);
    endtask

    initial begin
        int b;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.key_i = '0;
        bus.decrypt_i = 1'b0;
        bus.key_valid_i = 1'b0;
        bus.round_key_ready_i = 1'b0;
        #3;
        chk("rst_ready", 64'(bus.key_ready_o), 64'd1);
        chk("rst_valid", 64'(bus.round_key_valid_o), 64'd0);
        chk("rst_idx", 64'(bus.round_idx_o), 64'd0);
        chk("rst_last", 64'(bus.last_o), 64'd0);
        chk("rst_rk", 64'(bus.round_key_o), 64'd0);
        #19 rst_n = 1'b1;

        send_key(KEY_A, 1'b0); collect("enc", 1'b0, 1'b0, 1'b0);
        send_key(KEY_A, 1'b1); collect("dec", 1'b1, 1'b0, 1'b0);
        send_key(KEY_A, 1'b0); collect("enc_bp", 1'b0, 1'b1, 1'b0);
        send_key(KEY_A, 1'b1); collect("dec_bp", 1'b1, 1'b1, 1'b0);

        // All-ones key offered throughout the run must be ignored; the
        // parity-flipped key follows as soon as the schedule is free.
        send_key(KEY_A, 1'b0); collect("busy", 1'b0, 1'b0, 1'b1);
        send_key(KEY_A ^ PAR_MSK, 1'b0); collect("par_enc", 1'b0, 1'b0, 1'b0);
        send_key(KEY_A ^ PAR_MSK, 1'b1); collect("par_dec", 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-schedule at idx 7.
        send_key(KEY_A, 1'b0);
        b = 0;
        @(negedge clk);
        bus.round_key_ready_i = 1'b1;
        while (!(bus.round_key_valid_o && bus.round_idx_o == 4'd7) && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("mid_idx7", 64'(bus.round_idx_o), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.round_key_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.key_ready_o), 64'd1);
        chk("mid_rst_idx", 64'(bus.round_idx_o), 64'd0);
        chk("mid_rst_last", 64'(bus.last_o), 64'd0);
        @(negedge clk);
        chk("mid_rst_hold_valid", 64'(bus.round_key_valid_o), 64'd0);
        rst_n = 1'b1;
        send_key(KEY_A, 1'b0); collect("post_rst", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key schedule. Sits directly upstream of the Feistel round datapath.
- Accepts a 64-bit key once, then supplies the sixteen 48-bit round keys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- The round engine consumes round_key_o as its round_key input, one round per accepted key.

Parameters:
- none. All DES tables are fixed constants.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_i  input  64  DES key; bit 1 (DES numbering) = key_i[63]; parity bits ignored
- decrypt_i  input  1  sampled with key; 0 = K1..K16, 1 = K16..K1
- key_valid_i  input  1  key_i/decrypt_i valid
- key_ready_o  output  1  schedule idle, key accepted this cycle if key_valid_i
- round_key_o  output  48  current round key; DES bit 1 = round_key_o[47]
- round_idx_o  output  4  0..15, position of current key in the output sequence
- round_key_valid_o  output  1  round_key_o valid
- round_key_ready_i  input  1  consumer takes round_key_o this cycle
- last_o  output  1  high with the 16th key (round_idx_o == 15 && valid)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - C = D = 0, round_idx_o = 0, decrypt flag = 0.
  - round_key_valid_o = 0, last_o = 0, key_ready_o = 1.
- States: IDLE and RUN.
- Shift table: shift[r] = 1 for r = 1, 2, 9, 16; 2 for all other r in 1..16.
- IDLE:
  - key_ready_o = 1, round_key_valid_o = 0.
  - On key_valid_i && key_ready_o: (C0, D0) = PC-1(key_i), 28 bits each.
  - Encrypt: register C = C0 <<< 1, D = D0 <<< 1 (C1, D1).
  - Decrypt: register C = C0, D = D0, which equals C16/D16 because the shifts total 28.
  - Set round_idx = 0, latch decrypt_i, go to RUN.
- RUN:
  - key_ready_o = 0, round_key_valid_o = 1.
  - round_key_o = PC-2(C, D), combinational from registered C/D only. No other logic on the output path.
- Advance only on round_key_valid_o && round_key_ready_i. Holding ready low freezes all outputs indefinitely.
- Advance, encrypt: with n = round_idx_o + 1 (the round just emitted):
  - C, D <<<= shift[n+1].
  - round_idx++.
- Advance, decrypt: with j = 16 − round_idx_o (the key index just emitted):
  - C, D >>>= shift[j] (rotate right).
  - round_idx++.
- Advance at round_idx_o == 15:
  - No rotation. Go to IDLE, round_key_valid_o = 0 next cycle.
  - key_ready_o = 1 next cycle.
  - After the 16th handshake, C/D return to C0/D0 in both modes.
- Latency:
  - Key accepted at edge N → first key valid in cycle N+1.
  - Each later key is valid the cycle after the previous handshake.
  - Full schedule with ready held high: 16 cycles, then 1 IDLE cycle minimum before the next key.
- Key changes while in RUN:
  - key_valid_i is ignored (key_ready_o = 0).
  - The in-flight schedule is unaffected. No abort input exists.
- Mid-run reset returns immediately to the IDLE reset values. No partial key appears afterward.
- decrypt_i changes after acceptance have no effect.

Decomposition:
- des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries).
  - Shift table (16 entries).
  - Width constants: KEY_W = 64, HALF_W = 28, RK_W = 48, ROUNDS = 16.
- One natural sub-module, des_pc2: a purely combinational 56→48 selection driving round_key_o.
- PC-1 stays inline.

Test Plan:
- Encrypt vector: key 0x133457799BBCDFF1, decrypt 0, ready held 1.
  - idx 0 = 0x1B02EFFC7072, idx 1 = 0x79AED9DBC9E5, idx 15 = 0xCB3D8B0E17F5.
  - last_o only at idx 15; key_ready_o high 1 cycle after the 16th handshake.
- Decrypt vector: same key, decrypt 1.
  - idx 0 = 0xCB3D8B0E17F5, idx 14 = 0x79AED9DBC9E5, idx 15 = 0x1B02EFFC7072.
  - All 16 keys equal the encrypt sequence reversed.
- Backpressure: ready toggled pseudo-randomly.
  - Key sequence identical to the first two tests.
  - round_key_o/round_idx_o stable whenever valid && !ready.
- Busy rejection: present key 0xFFFFFFFFFFFFFFFF with key_valid_i during RUN.
  - Ignored; the sequence continues from 0x133457799BBCDFF1.
  - Back-to-back second key accepted when key_ready_o returns.
- Reset: assert rst_n low at idx 7 asynchronously (mid-cycle).
  - Outputs go to reset values immediately.
  - After release, a new key starts at idx 0 with the correct K1.
- Parity independence: key 0x133457799BBCDFF1 vs 0x123456789ABCDEF0 ^ parity-only differences, i.e. keys differing only in bits 8, 16, …, 64.
  - All 16 round keys identical.
